// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache.
// One CPU request is in flight at a time; misses talk to backing memory
// through a line-wide request/response port. Defining CACHE_STATS_EN adds
// hit_count / miss_count outputs that tally completed requests.
module data_cache #(
  parameter int LINE_COUNT  = 16,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      is_input_valid,
  input  logic [31:0]               addr,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [31:0]               din,
  output logic                      is_ready,
  output logic                      is_output_valid,
  output logic [31:0]               dout,
  output logic                      is_hit,
  output logic                      mem_req,
  output logic                      mem_req_write,
  output logic [31:0]               mem_req_addr,
  output logic [32*BLOCK_WORDS-1:0] mem_req_wdata,
  input  logic                      mem_req_ready,
  input  logic                      mem_resp_valid,
  input  logic [32*BLOCK_WORDS-1:0] mem_resp_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
`endif
);

  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int IDX_W  = $clog2(LINE_COUNT);
  localparam int TAG_W  = 32 - 2 - OFF_W - IDX_W;
  localparam int LINE_W = 32 * BLOCK_WORDS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WRITEBACK,
    ST_FILL,
    ST_RESPOND
  } state_t;

  state_t state, next_state;

  logic [31:0] req_addr;
  logic [31:0] req_din;
  logic        req_write;
  logic        req_sent;
  logic        first_lookup;
  logic        hit_flag;
  logic [31:0] resp_data;

  logic [LINE_COUNT-1:0] valid_bits;
  logic [LINE_COUNT-1:0] dirty_bits;
  logic [TAG_W-1:0]      tag_mem  [LINE_COUNT];
  logic [LINE_W-1:0]     data_mem [LINE_COUNT];

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             accept;
  logic             lookup_hit;
  logic             victim_dirty;
  logic [31:0]      lookup_word;
  logic             in_mem_state;
  logic             mem_accept;
  logic             resp_done;
  logic             unused_addr_lsbs;

  assign req_off  = req_addr[2 +: OFF_W];
  assign req_idx  = req_addr[2 + OFF_W +: IDX_W];
  assign req_tag  = req_addr[31 -: TAG_W];
  assign unused_addr_lsbs = ^req_addr[1:0];

  assign accept       = is_input_valid && (mem_read || mem_write);
  assign lookup_hit   = valid_bits[req_idx] && (tag_mem[req_idx] == req_tag);
  assign victim_dirty = valid_bits[req_idx] && dirty_bits[req_idx];
  assign lookup_word  = data_mem[req_idx][{req_off, 5'b0} +: 32];

  // A memory transaction completes once the request has been accepted
  // (possibly in this very cycle) and the response arrives.
  assign in_mem_state = (state == ST_WRITEBACK) || (state == ST_FILL);
  assign mem_accept   = in_mem_state && !req_sent && mem_req_ready;
  assign resp_done    = in_mem_state && mem_resp_valid && (req_sent || mem_req_ready);

  assign dout   = is_output_valid ? resp_data : 32'd0;
  assign is_hit = is_output_valid && hit_flag;

  // State register for the request FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic plus handshake and backing-memory request outputs
  always_comb begin
    next_state      = state;
    is_ready        = 1'b0;
    is_output_valid = 1'b0;
    mem_req         = 1'b0;
    mem_req_write   = 1'b0;
    mem_req_addr    = '0;
    mem_req_wdata   = '0;
    case (state)
      ST_IDLE: begin
        is_ready = 1'b1;
        if (accept) next_state = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (lookup_hit)        next_state = ST_RESPOND;
        else if (victim_dirty) next_state = ST_WRITEBACK;
        else                   next_state = ST_FILL;
      end
      ST_WRITEBACK: begin
        if (!req_sent) begin
          mem_req       = 1'b1;
          mem_req_write = 1'b1;
          mem_req_addr  = {tag_mem[req_idx], req_idx, {(OFF_W + 2){1'b0}}};
          mem_req_wdata = data_mem[req_idx];
        end
        if (resp_done) next_state = ST_FILL;
      end
      ST_FILL: begin
        if (!req_sent) begin
          mem_req      = 1'b1;
          mem_req_addr = {req_tag, req_idx, {(OFF_W + 2){1'b0}}};
        end
        if (resp_done) next_state = ST_LOOKUP;
      end
      ST_RESPOND: begin
        is_output_valid = 1'b1;
        next_state      = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Request capture, hit tracking and per-line valid/dirty bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_addr     <= '0;
      req_din      <= '0;
      req_write    <= 1'b0;
      req_sent     <= 1'b0;
      first_lookup <= 1'b0;
      hit_flag     <= 1'b0;
      resp_data    <= '0;
      valid_bits   <= '0;
      dirty_bits   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_addr     <= addr;
            req_din      <= din;
            req_write    <= mem_write;
            first_lookup <= 1'b1;
            hit_flag     <= 1'b0;
            resp_data    <= '0;
          end
        end
        ST_LOOKUP: begin
          if (lookup_hit) begin
            hit_flag  <= first_lookup;
            resp_data <= req_write ? 32'd0 : lookup_word;
            if (req_write) dirty_bits[req_idx] <= 1'b1;
          end else begin
            first_lookup <= 1'b0;
          end
        end
        ST_WRITEBACK: begin
          if (mem_accept) req_sent <= 1'b1;
          if (resp_done) begin
            req_sent            <= 1'b0;
            dirty_bits[req_idx] <= 1'b0;
          end
        end
        ST_FILL: begin
          if (mem_accept) req_sent <= 1'b1;
          if (resp_done) begin
            req_sent            <= 1'b0;
            valid_bits[req_idx] <= 1'b1;
            dirty_bits[req_idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Line data and tag storage; left unreset because valid bits gate every use
  always_ff @(posedge clk) begin
    if (state == ST_LOOKUP && lookup_hit && req_write)
      data_mem[req_idx][{req_off, 5'b0} +: 32] <= req_din;
    if (state == ST_FILL && resp_done) begin
      data_mem[req_idx] <= mem_resp_rdata;
      tag_mem[req_idx]  <= req_tag;
    end
  end

`ifdef CACHE_STATS_EN
  // Tally each completed request as a first-lookup hit or a miss
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == ST_RESPOND) begin
      if (hit_flag) hit_count  <= hit_count + 32'd1;
      else          miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: self-checking bench for data_cache. The bench plays the
// backing memory and keeps a line-level reference model of the cache.
module tb_data_cache;

  localparam int LC = 16;
  localparam int BW = 4;
  localparam int LW = 32 * BW;

  logic          clk = 1'b0;
  logic          reset;
  logic          is_input_valid;
  logic [31:0]   addr;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   din;
  logic          is_ready;
  logic          is_output_valid;
  logic [31:0]   dout;
  logic          is_hit;
  logic          mem_req;
  logic          mem_req_write;
  logic [31:0]   mem_req_addr;
  logic [LW-1:0] mem_req_wdata;
  logic          mem_req_ready;
  logic          mem_resp_valid;
  logic [LW-1:0] mem_resp_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;
`endif

  int checks = 0;
  int fails  = 0;

  // reference model state
  logic [31:0] m_data [LC][BW];
  bit          m_valid [LC];
  bit          m_dirty [LC];
  int unsigned m_tag [LC];
  logic [31:0] mem_words [int unsigned];

  bit            exp_write[$];
  logic [31:0]   exp_addr[$];
  logic [LW-1:0] exp_wdata[$];
  bit            obs_write[$];
  logic [31:0]   obs_addr[$];
  logic [LW-1:0] obs_wdata[$];
  int stall_seen, stall_unstable, busy_ready_high;

  data_cache #(.LINE_COUNT(LC), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
    .mem_read(mem_read), .mem_write(mem_write), .din(din), .is_ready(is_ready),
    .is_output_valid(is_output_valid), .dout(dout), .is_hit(is_hit),
    .mem_req(mem_req), .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [LW-1:0] mem_line(input logic [31:0] base);
    logic [LW-1:0] line;
    for (int w = 0; w < BW; w++) line[32*w +: 32] = mem_get(base + 32'(4 * w));
    return line;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LC; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // Predict hit/miss, load data and the memory transactions of one request
  task automatic model_access(input logic [31:0] a, input bit wr, input logic [31:0] d,
                              output bit hit, output logic [31:0] rdata);
    int unsigned idx, tag, off, base, vbase;
    logic [LW-1:0] line;
    exp_write.delete(); exp_addr.delete(); exp_wdata.delete();
    off  = (a / 4) % BW;
    idx  = (a / (4 * BW)) % LC;
    tag  = a / (4 * BW * LC);
    base = a - (a % (4 * BW));
    hit  = m_valid[idx] && (m_tag[idx] == tag);
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        vbase = (m_tag[idx] * LC + idx) * 4 * BW;
        for (int w = 0; w < BW; w++) begin
          line[32*w +: 32] = m_data[idx][w];
          mem_words[vbase + 4 * w] = m_data[idx][w];
        end
        exp_write.push_back(1'b1); exp_addr.push_back(vbase); exp_wdata.push_back(line);
      end
      exp_write.push_back(1'b0); exp_addr.push_back(base); exp_wdata.push_back('0);
      for (int w = 0; w < BW; w++) m_data[idx][w] = mem_get(base + 4 * w);
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
    end
    if (wr) begin
      m_data[idx][off] = d;
      m_dirty[idx] = 1'b1;
      rdata = 32'd0;
    end else begin
      rdata = m_data[idx][off];
    end
  endtask

  // Issue one request and act as the backing memory until the response pulse
  task automatic do_request(input logic [31:0] a, input logic rd, input logic wr,
                            input logic [31:0] d, input int ready_delay,
                            output logic [31:0] got_dout, output logic got_hit,
                            output int latency);
    int cycle, stall, resp_wait;
    bit pending, seen_req, first_wr;
    logic [31:0] first_addr;
    logic [LW-1:0] pend_rdata;
    obs_write.delete(); obs_addr.delete(); obs_wdata.delete();
    stall_seen = 0; stall_unstable = 0; busy_ready_high = 0;
    got_dout = '0; got_hit = 1'b0; latency = -1;
    pending = 0; seen_req = 0; stall = 0; resp_wait = 0;
    first_addr = '0; first_wr = 0; pend_rdata = '0;
    @(negedge clk);
    is_input_valid = 1'b1; addr = a; mem_read = rd; mem_write = wr; din = d;
    @(negedge clk);
    is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    cycle = 1;
    while (cycle <= 300) begin
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
      if (is_output_valid) begin
        got_dout = dout; got_hit = is_hit; latency = cycle;
        break;
      end
      if (is_ready) busy_ready_high++;
      if (pending) begin
        if (resp_wait == 0) begin
          mem_resp_valid = 1'b1; mem_resp_rdata = pend_rdata; pending = 0;
        end else resp_wait--;
      end else if (mem_req) begin
        if (!seen_req) begin
          first_addr = mem_req_addr; first_wr = mem_req_write; seen_req = 1;
        end else if (mem_req_addr !== first_addr || mem_req_write !== first_wr) begin
          stall_unstable++;
        end
        if (stall < ready_delay) begin
          stall++; stall_seen++;
        end else begin
          mem_req_ready = 1'b1;
          obs_write.push_back(mem_req_write);
          obs_addr.push_back(mem_req_addr);
          obs_wdata.push_back(mem_req_wdata);
          pend_rdata = mem_req_write ? '0 : mem_line(mem_req_addr);
          resp_wait = $urandom_range(0, 2);
          if (resp_wait == 0) begin
            mem_resp_valid = 1'b1; mem_resp_rdata = pend_rdata;
          end else begin
            pending = 1; resp_wait--;
          end
          seen_req = 0; stall = 0;
        end
      end
      @(negedge clk);
      cycle++;
    end
    checks++;
    if (latency < 0) begin
      fails++;
      $display("[TB] FAIL request_timeout: addr %h got no response, required one within 300 cycles", a);
    end
  endtask

  task automatic test_reset();
    #12;
    checks += 7;
    if (is_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_is_ready: got %b expected 1", is_ready); end
    if (is_output_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", is_output_valid); end
    if (dout !== 32'd0) begin fails++; $display("[TB] FAIL reset_dout: got %h expected 0", dout); end
    if (is_hit !== 1'b0) begin fails++; $display("[TB] FAIL reset_is_hit: got %b expected 0", is_hit); end
    if (mem_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
    if (mem_req_addr !== 32'd0) begin fails++; $display("[TB] FAIL reset_req_addr: got %h expected 0", mem_req_addr); end
    if (mem_req_wdata !== '0) begin fails++; $display("[TB] FAIL reset_req_wdata: got %h expected 0", mem_req_wdata); end
`ifdef CACHE_STATS_EN
    checks += 2;
    if (hit_count !== 32'd0) begin fails++; $display("[TB] FAIL reset_hit_count: got %0d expected 0", hit_count); end
    if (miss_count !== 32'd0) begin fails++; $display("[TB] FAIL reset_miss_count: got %0d expected 0", miss_count); end
`endif
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_no_op();
    @(negedge clk);
    is_input_valid = 1'b1; addr = 32'h40; mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    is_input_valid = 1'b0;
    checks++;
    if (is_ready !== 1'b1) begin fails++; $display("[TB] FAIL no_op_ready: got %b expected 1", is_ready); end
    repeat (2) @(negedge clk);
    checks += 2;
    if (is_output_valid !== 1'b0) begin fails++; $display("[TB] FAIL no_op_out_valid: got %b expected 0", is_output_valid); end
    if (mem_req !== 1'b0) begin fails++; $display("[TB] FAIL no_op_mem_req: got %b expected 0", mem_req); end
  endtask

  task automatic test_miss_fill();
    bit eh; logic [31:0] ed, gd; logic gh; int lat;
    mem_words[32'h10] = 32'd1; mem_words[32'h14] = 32'd2;
    mem_words[32'h18] = 32'd3; mem_words[32'h1C] = 32'd4;
    model_access(32'h10, 1'b0, 32'd0, eh, ed);
    do_request(32'h10, 1'b1, 1'b0, 32'd0, 0, gd, gh, lat);
    checks += 3;
    if (obs_write.size() !== 1) begin fails++; $display("[TB] FAIL miss_txn_count: got %0d expected 1", obs_write.size()); end
    if (gd !== 32'd1) begin fails++; $display("[TB] FAIL miss_dout: got %h expected 1", gd); end
    if (gh !== 1'b0) begin fails++; $display("[TB] FAIL miss_is_hit: got %b expected 0", gh); end
    if (obs_write.size() >= 1) begin
      checks += 2;
      if (obs_write[0] !== 1'b0) begin fails++; $display("[TB] FAIL miss_fill_kind: got %b expected 0", obs_write[0]); end
      if (obs_addr[0] !== 32'h10) begin fails++; $display("[TB] FAIL miss_fill_addr: got %h expected 10", obs_addr[0]); end
    end
    @(negedge clk);
    checks += 2;
    if (is_output_valid !== 1'b0) begin fails++; $display("[TB] FAIL pulse_width: got %b expected 0", is_output_valid); end
    if (dout !== 32'd0) begin fails++; $display("[TB] FAIL dout_idle: got %h expected 0", dout); end
  endtask

  task automatic test_hit_latency();
    bit eh; logic [31:0] ed, gd; logic gh; int lat;
    model_access(32'h14, 1'b0, 32'd0, eh, ed);
    do_request(32'h14, 1'b1, 1'b0, 32'd0, 0, gd, gh, lat);
    checks += 4;
    if (obs_write.size() !== 0) begin fails++; $display("[TB] FAIL hit_no_mem_req: got %0d expected 0", obs_write.size()); end
    if (lat !== 2) begin fails++; $display("[TB] FAIL hit_latency: got %0d expected 2", lat); end
    if (gd !== 32'd2) begin fails++; $display("[TB] FAIL hit_dout: got %h expected 2", gd); end
    if (gh !== 1'b1) begin fails++; $display("[TB] FAIL hit_is_hit: got %b expected 1", gh); end
  endtask

  task automatic test_writeback();
    bit eh; logic [31:0] ed, gd; logic gh; int lat;
    model_access(32'h10, 1'b1, 32'hDEAD_BEEF, eh, ed);
    do_request(32'h10, 1'b0, 1'b1, 32'hDEAD_BEEF, 0, gd, gh, lat);
    checks += 2;
    if (gh !== 1'b1) begin fails++; $display("[TB] FAIL store_hit: got %b expected 1", gh); end
    if (obs_write.size() !== 0) begin fails++; $display("[TB] FAIL store_no_mem: got %0d expected 0", obs_write.size()); end
    model_access(32'h110, 1'b0, 32'd0, eh, ed);
    do_request(32'h110, 1'b1, 1'b0, 32'd0, 0, gd, gh, lat);
    checks += 3;
    if (obs_write.size() !== 2) begin fails++; $display("[TB] FAIL wb_txn_count: got %0d expected 2", obs_write.size()); end
    if (gh !== 1'b0) begin fails++; $display("[TB] FAIL wb_is_hit: got %b expected 0", gh); end
    if (gd !== ed) begin fails++; $display("[TB] FAIL wb_dout: got %h expected %h", gd, ed); end
    if (obs_write.size() == 2) begin
      checks += 6;
      if (obs_write[0] !== 1'b1) begin fails++; $display("[TB] FAIL wb_kind: got %b expected 1", obs_write[0]); end
      if (obs_addr[0] !== 32'h10) begin fails++; $display("[TB] FAIL wb_addr: got %h expected 10", obs_addr[0]); end
      if (obs_wdata[0][31:0] !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL wb_word0: got %h expected deadbeef", obs_wdata[0][31:0]); end
      if (obs_wdata[0] !== exp_wdata[0]) begin fails++; $display("[TB] FAIL wb_line: got %h expected %h", obs_wdata[0], exp_wdata[0]); end
      if (obs_write[1] !== 1'b0) begin fails++; $display("[TB] FAIL wb_fill_kind: got %b expected 0", obs_write[1]); end
      if (obs_addr[1] !== 32'h110) begin fails++; $display("[TB] FAIL wb_fill_addr: got %h expected 110", obs_addr[1]); end
    end
  endtask

  task automatic test_stats();
`ifdef CACHE_STATS_EN
    checks += 2;
    if (hit_count !== 32'd2) begin fails++; $display("[TB] FAIL stats_hits: got %0d expected 2", hit_count); end
    if (miss_count !== 32'd2) begin fails++; $display("[TB] FAIL stats_misses: got %0d expected 2", miss_count); end
`endif
  endtask

  task automatic test_fill_stall();
    bit eh; logic [31:0] ed, gd; logic gh; int lat;
    model_access(32'h220, 1'b0, 32'd0, eh, ed);
    do_request(32'h220, 1'b1, 1'b0, 32'd0, 5, gd, gh, lat);
    checks += 6;
    if (stall_seen !== 5) begin fails++; $display("[TB] FAIL stall_cycles: got %0d expected 5", stall_seen); end
    if (stall_unstable !== 0) begin fails++; $display("[TB] FAIL stall_stable: got %0d changes expected 0", stall_unstable); end
    if (busy_ready_high !== 0) begin fails++; $display("[TB] FAIL stall_ready: got %0d busy cycles with is_ready expected 0", busy_ready_high); end
    if (obs_write.size() !== 1) begin fails++; $display("[TB] FAIL stall_txn_count: got %0d expected 1", obs_write.size()); end
    if (gh !== 1'b0) begin fails++; $display("[TB] FAIL stall_is_hit: got %b expected 0", gh); end
    if (gd !== ed) begin fails++; $display("[TB] FAIL stall_dout: got %h expected %h", gd, ed); end
  endtask

  task automatic test_reset_mid_fill();
    bit eh; logic [31:0] ed, gd; logic gh; int lat, n;
    model_access(32'h220, 1'b1, 32'hCAFE_0220, eh, ed);
    do_request(32'h220, 1'b0, 1'b1, 32'hCAFE_0220, 0, gd, gh, lat);
    checks++;
    if (gh !== 1'b1) begin fails++; $display("[TB] FAIL dirty_store_hit: got %b expected 1", gh); end
    @(negedge clk);
    is_input_valid = 1'b1; addr = 32'h10; mem_read = 1'b1; mem_write = 1'b0;
    @(negedge clk);
    is_input_valid = 1'b0; mem_read = 1'b0;
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (mem_req !== 1'b1) begin fails++; $display("[TB] FAIL mid_fill_req: got %b expected 1", mem_req); end
    if (mem_req) begin
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    checks += 2;
    if (is_ready !== 1'b1) begin fails++; $display("[TB] FAIL async_reset_ready: got %b expected 1", is_ready); end
    if (mem_req !== 1'b0) begin fails++; $display("[TB] FAIL async_reset_req: got %b expected 0", mem_req); end
    #1 reset = 1'b1;
    model_reset();
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_rdata = {BW{32'hBAD0_BAD0}};
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    checks += 3;
    if (is_ready !== 1'b1) begin fails++; $display("[TB] FAIL stale_resp_ready: got %b expected 1", is_ready); end
    if (is_output_valid !== 1'b0) begin fails++; $display("[TB] FAIL stale_resp_out: got %b expected 0", is_output_valid); end
    if (mem_req !== 1'b0) begin fails++; $display("[TB] FAIL stale_resp_req: got %b expected 0", mem_req); end
    model_access(32'h10, 1'b0, 32'd0, eh, ed);
    do_request(32'h10, 1'b1, 1'b0, 32'd0, 0, gd, gh, lat);
    checks += 3;
    if (gh !== 1'b0) begin fails++; $display("[TB] FAIL post_reset_hit: got %b expected 0", gh); end
    if (gd !== ed) begin fails++; $display("[TB] FAIL post_reset_dout: got %h expected %h", gd, ed); end
    if (obs_write.size() !== 1) begin fails++; $display("[TB] FAIL post_reset_txns: got %0d expected 1", obs_write.size()); end
    model_access(32'h220, 1'b0, 32'd0, eh, ed);
    do_request(32'h220, 1'b1, 1'b0, 32'd0, 0, gd, gh, lat);
    checks += 3;
    if (gh !== 1'b0) begin fails++; $display("[TB] FAIL lost_dirty_hit: got %b expected 0", gh); end
    if (gd !== ed) begin fails++; $display("[TB] FAIL lost_dirty_dout: got %h expected %h", gd, ed); end
    if (obs_write.size() !== 1) begin fails++; $display("[TB] FAIL lost_dirty_txns: got %0d expected 1", obs_write.size()); end
  endtask

  task automatic test_random();
    bit eh, wr, rd; logic [31:0] ed, gd, a, d; logic gh; int lat, op, nmin;
    for (int i = 0; i < 80; i++) begin
      a  = 32'((($urandom_range(0, 3) * LC + $urandom_range(0, 3)) * BW + $urandom_range(0, BW - 1)) * 4);
      op = $urandom_range(0, 2);
      rd = (op != 1);
      wr = (op != 0);
      d  = $urandom;
      model_access(a, wr, d, eh, ed);
      do_request(a, rd, wr, d, $urandom_range(0, 2), gd, gh, lat);
      checks += 2;
      if (gh !== eh) begin fails++; $display("[TB] FAIL rand_hit: addr %h got %b expected %b", a, gh, eh); end
      if (obs_write.size() !== exp_write.size()) begin fails++; $display("[TB] FAIL rand_txn_count: addr %h got %0d expected %0d", a, obs_write.size(), exp_write.size()); end
      if (!wr) begin
        checks++;
        if (gd !== ed) begin fails++; $display("[TB] FAIL rand_dout: addr %h got %h expected %h", a, gd, ed); end
      end
      if (eh) begin
        checks++;
        if (lat !== 2) begin fails++; $display("[TB] FAIL rand_hit_latency: got %0d expected 2", lat); end
      end
      nmin = (obs_write.size() < exp_write.size()) ? obs_write.size() : exp_write.size();
      for (int k = 0; k < nmin; k++) begin
        checks += 2;
        if (obs_write[k] !== exp_write[k]) begin fails++; $display("[TB] FAIL rand_txn_kind: got %b expected %b", obs_write[k], exp_write[k]); end
        if (obs_addr[k] !== exp_addr[k]) begin fails++; $display("[TB] FAIL rand_txn_addr: got %h expected %h", obs_addr[k], exp_addr[k]); end
        if (exp_write[k]) begin
          checks++;
          if (obs_wdata[k] !== exp_wdata[k]) begin fails++; $display("[TB] FAIL rand_wb_data: got %h expected %h", obs_wdata[k], exp_wdata[k]); end
        end
      end
      @(negedge clk);
      checks += 2;
      if (is_output_valid !== 1'b0) begin fails++; $display("[TB] FAIL rand_pulse: got %b expected 0", is_output_valid); end
      if (dout !== 32'd0) begin fails++; $display("[TB] FAIL rand_dout_idle: got %h expected 0", dout); end
    end
  endtask

  initial begin
    reset = 1'b0;
    is_input_valid = 1'b0; addr = '0; mem_read = 1'b0; mem_write = 1'b0; din = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    $display("[TB] starting data_cache bench");
    test_reset();
    test_no_op();
    test_miss_fill();
    test_hit_latency();
    test_writeback();
    test_stats();
    test_fill_stall();
    test_reset_mid_fill();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
